// File: rtl/alu_seq.sv
// alu_seq: registered sequential ALU on a shared bus.
// Two operand latches load from bus_in; start launches an opcode from IDLE.
// Single-cycle ops complete at the start edge; MUL is a WIDTH-step LSB-first
// shift-add. The result and the {V,C,N,Z} flags are registered and drive the
// bus through a tri-state output. busy/done give the handshake.
// Ports:
//   ALU_clock, ALU_reset      clock, async active-high reset
//   bus_in                    shared bus data
//   latched_bus1_en/2_en      load operand A / B from bus_in
//   control, start            opcode and launch strobe (honoured only in IDLE)
//   bus_out_en, bus_out       tri-state result output
//   busy, done, flags         MUL in progress, one-cycle completion pulse, {V,C,N,Z}
module alu_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             ALU_clock,
  input  logic             ALU_reset,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             latched_bus1_en,
  input  logic             latched_bus2_en,
  input  logic [3:0]       control,
  input  logic             start,
  input  logic             bus_out_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_op_a;
  logic [WIDTH-1:0]       r_op_b;
  logic [WIDTH-1:0]       r_result;
  logic [3:0]             r_flags;
  logic                   r_busy;
  logic                   r_done;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [2*WIDTH-1:0]     r_acc;
  logic [SHAMT_W-1:0]     r_iter;

  logic [SHAMT_W-1:0]     w_shamt;
  logic [WIDTH:0]         w_add;
  logic [WIDTH:0]         w_sub;
  logic [WIDTH:0]         w_shl;
  logic [WIDTH:0]         w_shr;
  logic [WIDTH:0]         w_asr;
  logic [WIDTH-1:0]       w_res;
  logic                   w_c;
  logic                   w_v;
  logic [2*WIDTH-1:0]     w_acc_next;
  logic                   w_mul_last;

  // Widened shifts: the extra bit catches the last bit shifted out (0 for amount 0)
  assign w_shamt = r_op_b[SHAMT_W-1:0];
  assign w_add   = {1'b0, r_op_a} + {1'b0, r_op_b};
  assign w_sub   = {1'b0, r_op_a} - {1'b0, r_op_b};
  assign w_shl   = {1'b0, r_op_a} << w_shamt;
  assign w_shr   = {r_op_a, 1'b0} >> w_shamt;
  assign w_asr   = (WIDTH+1)'($signed({r_op_a, 1'b0}) >>> w_shamt);

  // Single-cycle result and C/V
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (control)
      OP_ADD: begin
        w_res = w_add[MSB:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_op_a[MSB] == r_op_b[MSB]) && (w_add[MSB] != r_op_a[MSB]);
      end
      OP_SUB: begin
        w_res = w_sub[MSB:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_op_a[MSB] != r_op_b[MSB]) && (w_sub[MSB] != r_op_a[MSB]);
      end
      OP_NOT:  w_res = ~r_op_a;
      OP_AND:  w_res = r_op_a & r_op_b;
      OP_OR:   w_res = r_op_a | r_op_b;
      OP_XOR:  w_res = r_op_a ^ r_op_b;
      OP_XNOR: w_res = ~(r_op_a ^ r_op_b);
      OP_SHL: begin
        w_res = w_shl[MSB:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_ASR: begin
        w_res = w_asr[WIDTH:1];
        w_c   = w_asr[0];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // One shift-add step on the private copies
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_iter == SHAMT_W'(WIDTH - 1));

  // Operand latches, FSM, result/flag registers and handshake
  always_ff @(posedge ALU_clock or posedge ALU_reset) begin
    if (ALU_reset) begin
      r_state  <= S_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_iter   <= '0;
    end else begin
      if (latched_bus1_en) r_op_a <= bus_in;
      if (latched_bus2_en) r_op_b <= bus_in;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (control == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, r_op_a};
              r_mplier <= r_op_b;
              r_acc    <= '0;
              r_iter   <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              r_result <= w_res;
              r_flags  <= {w_v, w_c, w_res[MSB], (w_res == '0)};
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_iter   <= r_iter + SHAMT_W'(1);
          if (w_mul_last) begin
            r_result <= w_acc_next[MSB:0];
            r_flags  <= {1'b0, (w_acc_next[2*WIDTH-1:WIDTH] != '0),
                         w_acc_next[MSB], (w_acc_next[MSB:0] == '0)};
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_out = bus_out_en ? r_result : {WIDTH{1'bz}};
  assign busy    = r_busy;
  assign done    = r_done;
  assign flags   = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq against an
// arithmetic reference model (integer math on the operand values).
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         ALU_clock = 1'b0;
  logic         ALU_reset;
  logic [W-1:0] bus_in;
  logic         latched_bus1_en;
  logic         latched_bus2_en;
  logic [3:0]   control;
  logic         start;
  logic         bus_out_en;
  wire  [W-1:0] bus_out;
  logic         busy;
  logic         done;
  logic [3:0]   flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  alu_seq #(.WIDTH(W)) dut (
    .ALU_clock       (ALU_clock),
    .ALU_reset       (ALU_reset),
    .bus_in          (bus_in),
    .latched_bus1_en (latched_bus1_en),
    .latched_bus2_en (latched_bus2_en),
    .control         (control),
    .start           (start),
    .bus_out_en      (bus_out_en),
    .bus_out         (bus_out),
    .busy            (busy),
    .done            (done),
    .flags           (flags)
  );

  always #5 ALU_clock = ~ALU_clock;

  task automatic tick();
    @(posedge ALU_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: {V,C,N,Z, result} from plain integer arithmetic
  function automatic logic [19:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    int unsigned ua, ub, p, s;
    int          sa, sb, si;
    logic [W-1:0] res;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    s = b[3:0]; res = '0; c = 1'b0; v = 1'b0; p = 0; si = 0;
    case (op)
      4'd1: begin p = ua + ub; res = p[15:0]; c = (p > 32'hFFFF);
                  si = sa + sb; v = (si > 32767) || (si < -32768); end
      4'd2: begin p = ua - ub; res = p[15:0]; c = (ua < ub);
                  si = sa - sb; v = (si > 32767) || (si < -32768); end
      4'd3: res = ~a;
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd7: res = ~(a ^ b);
      4'd8: begin p = ua << s; res = p[15:0]; c = (s != 0) && (((ua >> (16 - s)) & 1) != 0); end
      4'd9: begin p = ua >> s; res = p[15:0]; c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      4'd10: begin si = sa >>> s; res = si[15:0]; c = (s != 0) && (((sa >>> (s - 1)) & 1) != 0); end
      4'd11: begin p = ua * ub; res = p[15:0]; c = ((p >> 16) != 0); end
      default: res = '0;
    endcase
    return {v, c, res[15], (res == 16'h0), res};
  endfunction

  task automatic load_a(input logic [W-1:0] v);
    bus_in = v; latched_bus1_en = 1'b1; tick(); latched_bus1_en = 1'b0; m_a = v;
  endtask

  task automatic load_b(input logic [W-1:0] v);
    bus_in = v; latched_bus2_en = 1'b1; tick(); latched_bus2_en = 1'b0; m_b = v;
  endtask

  // Launch op, measure latency/busy, compare result and flags, then poke start in DONE
  task automatic run_op(input string tag, input logic [3:0] op, input logic disturb);
    logic [19:0] exp;
    int lat, busy_cnt;
    exp = model(op, m_a, m_b);
    control = op; start = 1'b1;
    tick();
    start = 1'b0; control = 4'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (disturb && lat == 4) begin
        start = 1'b1; control = 4'd1;
        bus_in = W'($urandom);
        latched_bus1_en = 1'b1; latched_bus2_en = 1'b1;
        m_a = bus_in; m_b = bus_in;
      end
      tick();
      start = 1'b0; latched_bus1_en = 1'b0; latched_bus2_en = 1'b0;
      lat++;
    end
    check({tag, "_lat"}, lat, (op == 4'd11) ? 17 : 1);
    check({tag, "_busycyc"}, busy_cnt, (op == 4'd11) ? 16 : 0);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    check({tag, "_res"}, {16'd0, bus_out}, {16'd0, exp[15:0]});
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp[19:16]});
    // start in DONE must be ignored
    control = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_pulse"}, {30'd0, done, busy}, 0);
    check({tag, "_hold"}, {16'd0, bus_out}, {16'd0, exp[15:0]});
  endtask

  initial begin
    int ndone;
    logic released;
    ALU_reset = 1'b1; bus_in = '0; latched_bus1_en = 1'b0; latched_bus2_en = 1'b0;
    control = '0; start = 1'b0; bus_out_en = 1'b1; m_a = '0; m_b = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_flags", {28'd0, flags}, 0);
    check("rst_bus", {16'd0, bus_out}, 0);
    @(negedge ALU_clock); ALU_reset = 1'b0;
    tick();

    load_a(16'h7FFF); load_b(16'h0001);
    run_op("add", 4'd1, 1'b0);
    check("add_k", {12'd0, flags, bus_out}, {12'd0, 4'b1010, 16'h8000});

    load_a(16'h0003); load_b(16'h0005);
    run_op("sub", 4'd2, 1'b0);
    check("sub_k", {12'd0, flags, bus_out}, {12'd0, 4'b0110, 16'hFFFE});

    load_a(16'h1234); load_b(16'h1234);
    run_op("xnor", 4'd7, 1'b0);
    check("xnor_k", {12'd0, flags, bus_out}, {12'd0, 4'b0010, 16'hFFFF});

    load_a(16'h0123); load_b(16'h0045);
    run_op("mul", 4'd11, 1'b1);
    check("mul_k", {12'd0, flags, bus_out}, {12'd0, 4'b0000, 16'h4E6F});

    load_a(16'h1000); load_b(16'h0010);
    run_op("mulz", 4'd11, 1'b0);
    check("mulz_k", {12'd0, flags, bus_out}, {12'd0, 4'b0101, 16'h0000});

    load_a(16'h8001); load_b(16'h0001);
    run_op("asr", 4'd10, 1'b0);
    check("asr_k", {12'd0, flags, bus_out}, {12'd0, 4'b0110, 16'hC000});

    // bus release and re-drive
    bus_out_en = 1'b0; #1;
    released = (bus_out === {W{1'bz}}) || (bus_out === {W{1'b0}});
    check("bus_release", {31'd0, released}, 1);
    bus_out_en = 1'b1; #1;
    check("bus_redrive", {16'd0, bus_out}, 32'h0000C000);

    // both latches in one edge
    bus_in = 16'h00AA; latched_bus1_en = 1'b1; latched_bus2_en = 1'b1;
    tick();
    latched_bus1_en = 1'b0; latched_bus2_en = 1'b0; m_a = 16'h00AA; m_b = 16'h00AA;
    run_op("and_both", 4'd4, 1'b0);
    check("and_k", {16'd0, bus_out}, 32'h000000AA);

    // async reset in the middle of a multiply
    load_a(16'h0123); load_b(16'h0045);
    control = 4'd11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_busy", {31'd0, busy}, 1);
    #2 ALU_reset = 1'b1;
    #1;
    check("arst_state", {10'd0, busy, done, flags, bus_out}, 0);
    #2 ALU_reset = 1'b0;
    m_a = '0; m_b = '0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    check("arst_nodone", ndone, 0);
    check("arst_res", {12'd0, flags, bus_out}, 0);

    // randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 1) == 1) load_a(W'($urandom));
      if ($urandom_range(0, 1) == 1) load_b(W'($urandom));
      op = ($urandom_range(0, 4) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
